hex_expr_parser: RTL
====================

Name: hex_expr_parser

Overview:
Parametrised ASCII expression parser for the UART hex calculator. Sits between the UART RX byte stream and the ALU.
- Accepts expressions of the form "[S|U] <hex operand1> <op> <hex operand2> =".
- Builds DATA_W-bit operands and applies sign extension in signed mode.
- Hands one command to the ALU through a valid/ready handshake.
- Detects malformed input and reports it with an error code.

Parameters:
DATA_W, 16, operand width in bits; must be a multiple of 4, range 8..64. Local MAX_DIG = DATA_W/4.

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
rx_data  input  8  ASCII byte from UART RX
rx_valid  input  1  rx_data valid
rx_ready  output  1  parser can accept a byte
cmd_valid  output  1  parsed command available
cmd_ready  input  1  ALU accepts command
cmd_op  output  3  1 '+', 2 '-', 3 '*', 4 '/'
cmd_signed  output  1  1 = signed mode
cmd_src1  output  DATA_W  operand 1, extended to DATA_W
cmd_src2  output  DATA_W  operand 2, extended to DATA_W
err_valid  output  1  one-cycle error pulse
err_code  output  2  1 bad char, 2 digit overflow, 3 missing operand

Behaviour:
- Reset values: all outputs 0 except rx_ready=1. FSM state = IDLE, mode = unsigned, accumulators and digit counters = 0.
- Byte accept: a byte is consumed on a clock edge where rx_valid && rx_ready. rx_ready = (state != HOLD).
- Space (0x20): ignored in every state.
- CR (0x0D) or LF (0x0A): silent abort to IDLE from any state except HOLD. Clears accumulators; no error.
- FSM states: IDLE, SRC1, SRC2, HOLD.
- IDLE:
  - 'S' (0x53) sets signed mode; 'U' (0x55) sets unsigned mode; state stays IDLE.
  - A hex digit loads acc1 = digit, cnt1 = 1, and moves to SRC1.
  - An operator or '=' raises error 3.
  - Any other byte raises error 1.
- SRC1:
  - Hex digit: acc1 = {acc1, digit}, cnt1+1. If cnt1 == MAX_DIG already, raise error 2.
  - Operator (0x2B '+', 0x2D '-', 0x2A '*', 0x2F '/'): latch op, move to SRC2.
  - '=' raises error 3. Any other byte raises error 1.
- SRC2:
  - Hex digit: accumulates into acc2/cnt2 with the same overflow rule.
  - '=' with cnt2 >= 1 moves to HOLD.
  - '=' with cnt2 == 0 raises error 3.
  - An operator byte in SRC2 raises error 1.
- HOLD:
  - cmd_valid=1. All cmd_* outputs are stable until the handshake.
  - On cmd_valid && cmd_ready, the next state is IDLE. Accumulators, counters and mode are cleared; cmd_valid drops in the same edge.
  - Mode reverts to unsigned after each command.
- Latency: '=' consumed at edge N gives cmd_valid=1 after edge N. When cmd_ready is held high, the earliest next byte is accepted at edge N+2.
- Operand extension (operands with n digits):
  - Unsigned: zero-extend from 4n bits.
  - Signed: sign-extend from bit 4n-1.
  - Extension is registered into cmd_src1/cmd_src2 on the transition into HOLD.
- Error:
  - err_valid=1 for exactly the cycle after the offending byte, with err_code set.
  - State returns to IDLE; accumulators, counters and mode are cleared.
  - err_code holds its value until the next error; err_valid does not hold.
- Digit set: 0x30-0x39 map to 0-9; 0x41-0x46 map to A-F.
- Reset mid-expression or in HOLD: immediate return to reset values; no cmd_valid or err_valid is produced.
- rx_valid low: no state change.
- cmd_ready outside HOLD: ignored.

Optional Feature:
- Macro: HEX_PARSER_LOWER_EN.
- Defined: lowercase 'a'-'f' (0x61-0x66) are accepted as digits A-F, and 's'/'u' (0x73/0x75) as mode selectors, with identical timing.
- Undefined: these bytes are bad characters and raise error 1.

Test Plan:
- DATA_W=16, bytes "12+34=", cmd_ready=1 -> one cmd_valid pulse with op=1, src1=0x0012, src2=0x0034, signed=0. rx_ready is low for exactly one cycle.
- "S F * 7 =" -> signed=1, op=3, src1=0xFFFF, src2=0x0007. A following "F*7=" gives src1=0x000F (mode reverts).
- "12345+1=" with DATA_W=16 -> err_valid pulse, err_code=2 at the fifth digit. The remaining "+1=" gives error 3 at '+', then error 1 at '1'... rather: '+' in IDLE gives err 3, '1' starts a new SRC1, and '=' gives err 3.
- "A-=", then "A-G" -> err_code=3 at '=', then err_code=1 at 'G'. No cmd_valid in either case.
- "1/2=" with cmd_ready=0 for 5 cycles while rx_valid stays high with '3' -> rx_ready=0 and cmd outputs stable. After cmd_ready=1, the '3' is accepted on the following cycle into SRC1.
- n_rst asserted mid "AB+C" and in HOLD -> all outputs return to reset values. "1+1=" afterwards parses normally.

Source files
------------

// File: rtl/hex_expr_parser.sv
// Purpose : ASCII "[S|U] <hex> <op> <hex> =" parser feeding one command per expression to the ALU.
// Latency : '=' consumed at edge N -> cmd_valid high after edge N; error pulse one cycle after the bad byte.
// Backpr. : rx_ready drops while a command waits in HOLD; cmd_* hold steady until cmd_valid && cmd_ready.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready   ASCII byte stream from UART RX
//   cmd_valid/cmd_ready     command handshake towards the ALU
//   cmd_op                  1 '+', 2 '-', 3 '*', 4 '/'
//   cmd_signed              1 = operands were sign-extended
//   cmd_src1/cmd_src2       operands extended to DATA_W
//   err_valid/err_code      one-cycle error pulse; code 1 bad char, 2 digit overflow, 3 missing operand
//
// Build option: define HEX_PARSER_LOWER_EN to also accept 'a'-'f' as digits and 's'/'u' as mode selectors.
module hex_expr_parser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic              cmd_signed,
    output logic [DATA_W-1:0] cmd_src1,
    output logic [DATA_W-1:0] cmd_src2,
    output logic              err_valid,
    output logic [1:0]        err_code
);
    localparam int MAX_DIG = DATA_W / 4;
    localparam int CNT_W   = $clog2(MAX_DIG + 1);

    typedef enum logic [1:0] {IDLE, SRC1, SRC2, HOLD} state_t;

    state_t             state;
    logic [DATA_W-1:0]  acc1, acc2;
    logic [CNT_W-1:0]   cnt1, cnt2;
    logic [2:0]         op_lat;
    logic               signed_mode;

    // Byte classification
    logic       is_dig, is_op, is_eq, is_space, is_eol, is_sel_s, is_sel_u;
    logic [3:0] dig_val;
    logic [2:0] op_val;
    logic       byte_take, do_clear;
    logic [1:0] err_now;

    // Zero- or sign-extend an n-digit accumulator; nibbles above the entered digits are filled.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] acc,
                                                 input logic [CNT_W-1:0]  cnt,
                                                 input logic              sgn);
        logic fill;
        fill   = 1'b0;
        extend = acc;
        for (int i = 0; i < MAX_DIG; i++)
            if (sgn && (CNT_W'(i + 1) == cnt))
                fill = acc[4*i+3];
        for (int i = 0; i < MAX_DIG; i++)
            if (CNT_W'(i) >= cnt)
                extend[4*i +: 4] = {4{fill}};
    endfunction

    always_comb begin
        is_dig  = 1'b0;
        dig_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_dig  = 1'b1;
            dig_val = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_dig  = 1'b1;
            dig_val = rx_data[3:0] + 4'd9;
        end
`ifdef HEX_PARSER_LOWER_EN
        else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_dig  = 1'b1;
            dig_val = rx_data[3:0] + 4'd9;
        end
`endif

        is_op  = 1'b1;
        op_val = 3'd0;
        case (rx_data)
            8'h2B:   op_val = 3'd1;
            8'h2D:   op_val = 3'd2;
            8'h2A:   op_val = 3'd3;
            8'h2F:   op_val = 3'd4;
            default: is_op  = 1'b0;
        endcase

        is_eq    = (rx_data == 8'h3D);
        is_space = (rx_data == 8'h20);
        is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
`ifdef HEX_PARSER_LOWER_EN
        is_sel_s = (rx_data == 8'h53) || (rx_data == 8'h73);
        is_sel_u = (rx_data == 8'h55) || (rx_data == 8'h75);
`else
        is_sel_s = (rx_data == 8'h53);
        is_sel_u = (rx_data == 8'h55);
`endif
    end

    assign rx_ready  = (state != HOLD);
    // Spaces are consumed but never change anything, so they are not "taken".
    assign byte_take = rx_valid && rx_ready && !is_space;

    always_comb begin
        err_now = 2'd0;
        if (byte_take && !is_eol) begin
            case (state)
                IDLE: if (is_op || is_eq)                      err_now = 2'd3;
                      else if (!is_dig && !is_sel_s && !is_sel_u) err_now = 2'd1;
                SRC1: if (is_dig && cnt1 == CNT_W'(MAX_DIG))    err_now = 2'd2;
                      else if (is_eq)                           err_now = 2'd3;
                      else if (!is_dig && !is_op)               err_now = 2'd1;
                SRC2: if (is_dig && cnt2 == CNT_W'(MAX_DIG))    err_now = 2'd2;
                      else if (is_eq && cnt2 == '0)             err_now = 2'd3;
                      else if (!is_dig && !is_eq)               err_now = 2'd1;
                default: err_now = 2'd0;
            endcase
        end
    end

    // Everything that returns the parser to a fresh IDLE: handshake, abort, error.
    assign do_clear = ((state == HOLD) && cmd_ready) ||
                      (byte_take && (is_eol || (err_now != 2'd0)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            acc1        <= '0;
            acc2        <= '0;
            cnt1        <= '0;
            cnt2        <= '0;
            op_lat      <= 3'd0;
            signed_mode <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_op      <= 3'd0;
            cmd_signed  <= 1'b0;
            cmd_src1    <= '0;
            cmd_src2    <= '0;
            err_valid   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            err_valid <= 1'b0;
            if (do_clear) begin
                state       <= IDLE;
                acc1        <= '0;
                acc2        <= '0;
                cnt1        <= '0;
                cnt2        <= '0;
                op_lat      <= 3'd0;
                signed_mode <= 1'b0;
                cmd_valid   <= 1'b0;
                if (err_now != 2'd0) begin
                    err_valid <= 1'b1;
                    err_code  <= err_now;
                end
            end else if (byte_take) begin
                case (state)
                    IDLE: begin
                        if (is_dig) begin
                            acc1  <= {{(DATA_W-4){1'b0}}, dig_val};
                            cnt1  <= CNT_W'(1);
                            state <= SRC1;
                        end else begin
                            // Only the mode selectors survive the error check here.
                            signed_mode <= is_sel_s;
                        end
                    end
                    SRC1: begin
                        if (is_dig) begin
                            acc1 <= {acc1[DATA_W-5:0], dig_val};
                            cnt1 <= cnt1 + 1'b1;
                        end else begin
                            op_lat <= op_val;
                            state  <= SRC2;
                        end
                    end
                    SRC2: begin
                        if (is_dig) begin
                            acc2 <= {acc2[DATA_W-5:0], dig_val};
                            cnt2 <= cnt2 + 1'b1;
                        end else begin
                            // '=' with at least one digit: publish the command.
                            cmd_valid  <= 1'b1;
                            cmd_op     <= op_lat;
                            cmd_signed <= signed_mode;
                            cmd_src1   <= extend(acc1, cnt1, signed_mode);
                            cmd_src2   <= extend(acc2, cnt2, signed_mode);
                            state      <= HOLD;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
